mem_access_ctrl: RTL

Sequences data-memory accesses from the MEM stage onto a 16-bit-wide, multi-cycle external SRAM.
- Each 32-bit word is transferred as two 16-bit halves, low half first.
- Pipeline freeze is exposed as `ready`; the pipeline must hold its MEM-stage registers while `ready=0`.
- Sits between the MEM stage (ALU result, Rm value, MEM_R_EN/MEM_W_EN) and the SRAM pins.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/wait_counter.sv | 48 ++++
 rtl/mem_access_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the MEM-stage SRAM access controller.
//   state_e  : access sequencer state (IDLE -> LOW -> HIGH -> DONE -> IDLE)
//   HALF_W   : width of one SRAM transfer (half of a CPU word)
//   HALF_LO  : half-word select bit appended to the word address, low half
//   HALF_HI  : half-word select bit appended to the word address, high half
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int   HALF_W  = 16;
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage : mem_ctrl_pkg

// File: rtl/wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Counts the cycles a single 16-bit SRAM access has been held and flags the
// last one.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears the count
//   clear  : return the count to 0 on the next edge (has priority over enable)
//   enable : advance the count by one on the next edge
//   last   : high while enabled and the count is WAIT_CYCLES-1
// Parameter WAIT_CYCLES (>=1) is the number of cycles per access.
// -----------------------------------------------------------------------------
module wait_counter #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    // A single-cycle access still needs a 1-bit counter to keep widths legal.
    localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = enable && (count_q == LAST_CNT);

endmodule : wait_counter

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Sequences MEM-stage loads/stores onto a 16-bit multi-cycle SRAM. Each 32-bit
// word is moved as two halves, low half first, each held WAIT_CYCLES cycles.
// The pipeline must hold its MEM-stage registers while ready=0.
//
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   MEM_R_EN      : load request
//   MEM_W_EN      : store request (wins if asserted together with MEM_R_EN)
//   ALU_Res       : word-aligned byte address
//   Val_Rm        : store data
//   ready         : no access pending, or access finishing this cycle
//   rdata         : load result, held until the next load overwrites it
//   SRAM_ADDR     : SRAM half-word address
//   SRAM_DQ_out   : SRAM write data
//   SRAM_DQ_in    : SRAM read data
//   SRAM_WE_N     : SRAM write strobe, active low
//
// Build option MEM_CTRL_STATS_EN adds:
//   stall_cycles  : cycles with ready=0 since reset, saturating
//   access_count  : completed accesses since reset, wrapping
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int N           = 32,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [N-1:0]      ALU_Res,
    input  logic [N-1:0]      Val_Rm,
    output logic              ready,
    output logic [N-1:0]      rdata,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [HALF_W-1:0] SRAM_DQ_out,
    input  logic [HALF_W-1:0] SRAM_DQ_in,
    output logic              SRAM_WE_N
`ifdef MEM_CTRL_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       access_count
`endif
);

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-2:0]   word_q;
    logic [ADDR_W-2:0]   word_d;
    logic [N-1:0]        wdata_q;
    logic                is_write_q;
    logic [N-1:0]        rdata_q;

    logic                req;
    logic [N-1:0]        offset;
    logic                unused_offset_bits;
    logic                cnt_clear;
    logic                cnt_en;
    logic                cnt_last;
    logic                capture_lo;
    logic                capture_hi;

    assign req = MEM_R_EN | MEM_W_EN;

    // Word index relative to the SRAM window; byte-lane bits and anything above
    // the SRAM word range are dropped, so out-of-window addresses simply wrap.
    assign offset             = ALU_Res - N'(BASE_ADDR);
    assign word_d             = offset[ADDR_W:2];
    assign unused_offset_bits = ^{offset[N-1:ADDR_W+1], offset[1:0]};

    wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .enable(cnt_en),
        .last  (cnt_last)
    );

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_DQ_out = '0;
        SRAM_WE_N   = 1'b1;
        cnt_en      = 1'b0;
        cnt_clear   = 1'b1;

        unique case (state_q)
            IDLE: begin
                // Combinational so the pipeline freezes in the request cycle.
                ready = !req;
                if (req) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                cnt_en    = 1'b1;
                cnt_clear = cnt_last;
                SRAM_ADDR = {word_q, HALF_LO};
                if (is_write_q) begin
                    SRAM_DQ_out = wdata_q[HALF_W-1:0];
                    SRAM_WE_N   = 1'b0;
                end
                if (cnt_last) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                cnt_en    = 1'b1;
                cnt_clear = cnt_last;
                SRAM_ADDR = {word_q, HALF_HI};
                if (is_write_q) begin
                    SRAM_DQ_out = wdata_q[N-1:HALF_W];
                    SRAM_WE_N   = 1'b0;
                end
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The pipeline advances on this edge, so a still-asserted
                // request belongs to the finished instruction: never restart.
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data is sampled on the last held cycle of each half.
    assign capture_lo = (state_q == LOW)  && cnt_last && !is_write_q;
    assign capture_hi = (state_q == HIGH) && cnt_last && !is_write_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && req) begin
                word_q     <= word_d;
                wdata_q    <= Val_Rm;
                // Read and write together is illegal; resolve it as a write.
                is_write_q <= MEM_W_EN;
            end
            if (capture_lo) begin
                rdata_q[HALF_W-1:0] <= SRAM_DQ_in;
            end
            if (capture_hi) begin
                rdata_q[N-1:HALF_W] <= SRAM_DQ_in;
            end
        end
    end

    assign rdata = rdata_q;

`ifdef MEM_CTRL_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] access_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            access_count_q <= '0;
        end else begin
            if (!ready && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if ((state_d == DONE) && (state_q != DONE)) begin
                access_count_q <= access_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign access_count = access_count_q;
`endif

endmodule : mem_access_ctrl
